// File: rtl/dvp_frame_tx.sv
// Purpose: camera-side DVP transmitter that turns a 16-bit RGB565 stream into OV5640-style 8-bit DVP frames.
// Latency: one pclk from a pix_ready edge to the high byte on dvp_data; the low byte follows on the next pclk.
// Backpressure: none toward the DVP side. The source is polled once per pixel, and a missing pixel is sent as zeros and flagged as underflow.
//
// Ports:
//   pclk, rst_n    pixel/byte clock, asynchronous active-low reset
//   enable         run request, sampled only at frame boundaries (IDLE or end of frame)
//   pix_data/_valid/pix_ready
//                  RGB565 pixel source; pix_ready is combinational and marks the edge that takes a pixel
//   underflow_clr  clears the sticky underflow flag (a new underflow on the same edge wins)
//   dvp_vsync, dvp_href, dvp_data
//                  registered DVP outputs
//   underflow, frame_start, busy
//                  registered status outputs
module dvp_frame_tx #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 144,
    parameter int VS_LINES = 4,
    parameter int V_BACK   = 16,
    parameter int V_FRONT  = 8
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic        underflow_clr,
    output logic        dvp_vsync,
    output logic        dvp_href,
    output logic [7:0]  dvp_data,
    output logic        underflow,
    output logic        frame_start,
    output logic        busy
);

    localparam int LP = 2 * H_ACTIVE + H_BLANK;
    localparam int HW = $clog2(LP) + 1;

    localparam int V_MAX_A = (VS_LINES > V_BACK)  ? VS_LINES : V_BACK;
    localparam int V_MAX_B = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int V_MAX   = (V_MAX_A > V_MAX_B)  ? V_MAX_A  : V_MAX_B;
    localparam int VW      = $clog2(V_MAX) + 1;

    localparam logic [HW-1:0] H_LAST      = HW'(LP - 1);
    localparam logic [HW-1:0] H_ACT_BYTES = HW'(2 * H_ACTIVE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBACK,
        S_ACTIVE,
        S_VFRONT
    } state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   h_cnt_q, h_cnt_d;
    logic [VW-1:0]   v_cnt_q, v_cnt_d;
    logic [VW-1:0]   v_last;
    logic [7:0]      lo_byte_q;
    logic            href_d;

    logic            dvp_vsync_q;
    logic            dvp_href_q;
    logic [7:0]      dvp_data_q;
    logic            underflow_q;
    logic            frame_start_q;
    logic            busy_q;

    // Last line index of the state being counted.
    always_comb begin
        v_last = '0;
        case (state_q)
            S_VSYNC:  v_last = VW'(VS_LINES - 1);
            S_VBACK:  v_last = VW'(V_BACK - 1);
            S_ACTIVE: v_last = VW'(V_ACTIVE - 1);
            S_VFRONT: v_last = VW'(V_FRONT - 1);
            default:  v_last = '0;
        endcase
    end

    // Next state and counters. Zero-length back/front porches are skipped.
    // enable is looked at only when leaving IDLE or finishing a frame,
    // so a frame in progress always runs to completion.
    always_comb begin
        state_d = state_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (state_q == S_IDLE) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
            if (enable) begin
                state_d = S_VSYNC;
            end
        end else if (h_cnt_q != H_LAST) begin
            h_cnt_d = h_cnt_q + 1'b1;
        end else begin
            h_cnt_d = '0;
            if (v_cnt_q != v_last) begin
                v_cnt_d = v_cnt_q + 1'b1;
            end else begin
                v_cnt_d = '0;
                case (state_q)
                    S_VSYNC:  state_d = (V_BACK > 0) ? S_VBACK : S_ACTIVE;
                    S_VBACK:  state_d = S_ACTIVE;
                    S_ACTIVE: begin
                        if (V_FRONT > 0) begin
                            state_d = S_VFRONT;
                        end else begin
                            state_d = enable ? S_VSYNC : S_IDLE;
                        end
                    end
                    S_VFRONT: state_d = enable ? S_VSYNC : S_IDLE;
                    default:  state_d = S_IDLE;
                endcase
            end
        end
    end

    // Outputs are registered from the next-state values, so they line up
    // with the state/counter they describe. A pixel is taken on the edge
    // that puts its high byte (even byte index) on the bus.
    assign href_d    = (state_d == S_ACTIVE) && (h_cnt_d < H_ACT_BYTES);
    assign pix_ready = href_d && !h_cnt_d[0];

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            lo_byte_q     <= 8'h00;
            dvp_vsync_q   <= 1'b0;
            dvp_href_q    <= 1'b0;
            dvp_data_q    <= 8'h00;
            underflow_q   <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            dvp_vsync_q   <= (state_d == S_VSYNC);
            dvp_href_q    <= href_d;
            frame_start_q <= (state_d == S_VSYNC) && (state_q != S_VSYNC);
            busy_q        <= (state_d != S_IDLE);

            // A missing pixel goes out as two zero bytes; timing is untouched.
            if (pix_ready) begin
                dvp_data_q <= pix_valid ? pix_data[15:8] : 8'h00;
                lo_byte_q  <= pix_valid ? pix_data[7:0]  : 8'h00;
            end else if (href_d) begin
                dvp_data_q <= lo_byte_q;
            end else begin
                dvp_data_q <= 8'h00;
            end

            // Set has priority over clear.
            if (pix_ready && !pix_valid) begin
                underflow_q <= 1'b1;
            end else if (underflow_clr) begin
                underflow_q <= 1'b0;
            end
        end
    end

    assign dvp_vsync   = dvp_vsync_q;
    assign dvp_href    = dvp_href_q;
    assign dvp_data    = dvp_data_q;
    assign underflow   = underflow_q;
    assign frame_start = frame_start_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_dvp_frame_tx.sv
// Purpose: directed self-checking bench for dvp_frame_tx with a small frame geometry.
// Latency: checks one-clock pixel-to-byte latency and exact per-clock frame timing.
// Backpressure: the source follows pix_ready; underflow is injected on chosen pixel pulses.
module tb_dvp_frame_tx;

    localparam int H_ACTIVE = 4;
    localparam int V_ACTIVE = 2;
    localparam int H_BLANK  = 3;
    localparam int VS_LINES = 1;
    localparam int V_BACK   = 1;
    localparam int V_FRONT  = 1;

    // Hand-derived geometry: LP = 8 + 3 = 11, frame = (1+1+2+1)*11 = 55.
    localparam int LP        = 11;
    localparam int FRAME     = 55;
    localparam int VS_END    = 11;
    localparam int ACT_START = 22;
    localparam int ACT_END   = 44;

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] pix_data = 16'h0000;
    logic        pix_valid = 1'b0;
    logic        underflow_clr = 1'b0;
    logic        pix_ready;
    logic        dvp_vsync;
    logic        dvp_href;
    logic [7:0]  dvp_data;
    logic        underflow;
    logic        frame_start;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] pix_mem [8] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0,
                                 16'h1357, 16'h2468, 16'hACE0, 16'hBDF1};
    int src_idx = 0;
    bit exp_uf  = 1'b0;

    dvp_frame_tx #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .H_BLANK  (H_BLANK),
        .VS_LINES (VS_LINES),
        .V_BACK   (V_BACK),
        .V_FRONT  (V_FRONT)
    ) dut (
        .pclk          (pclk),
        .rst_n         (rst_n),
        .enable        (enable),
        .pix_data      (pix_data),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .underflow_clr (underflow_clr),
        .dvp_vsync     (dvp_vsync),
        .dvp_href      (dvp_href),
        .dvp_data      (dvp_data),
        .underflow     (underflow),
        .frame_start   (frame_start),
        .busy          (busy)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Expected href at frame clock c.
    function automatic bit e_href(input int c);
        if (c < ACT_START || c >= ACT_END) return 1'b0;
        return ((c - ACT_START) % LP) < 2 * H_ACTIVE;
    endfunction

    // pix_ready is expected on the clock before an even-index href byte.
    function automatic bit e_rdy(input int c);
        return e_href(c + 1) && ((((c + 1 - ACT_START) % LP) % 2) == 0);
    endfunction

    task automatic check_all_zero(input string why);
        check({why, " vsync"},  int'(dvp_vsync),   0);
        check({why, " href"},   int'(dvp_href),    0);
        check({why, " data"},   int'(dvp_data),    0);
        check({why, " uf"},     int'(underflow),   0);
        check({why, " fstart"}, int'(frame_start), 0);
        check({why, " busy"},   int'(busy),        0);
        check({why, " rdy"},    int'(pix_ready),   0);
    endtask

    // Entered at frame clock 0 (the clock right after the edge that starts VSYNC).
    // uf_pulse: pixel pulse number sent with pix_valid=0 (-1 none)
    // clr_at / en_off_at / rst_at: frame clock at which to act (-1 none)
    task automatic run_frame(input int uf_pulse, input int clr_at,
                             input int en_off_at, input int rst_at);
        logic [7:0] exp_data;
        logic [7:0] nxt_data;
        logic [7:0] lo_hold;
        int         pulse;
        int         rdy_cnt;
        bit         v;
        exp_data = 8'h00;
        lo_hold  = 8'h00;
        pulse    = 0;
        rdy_cnt  = 0;
        for (int c = 0; c < FRAME; c++) begin
            check($sformatf("vsync c=%0d", c),  int'(dvp_vsync),   int'(c < VS_END));
            check($sformatf("href c=%0d", c),   int'(dvp_href),    int'(e_href(c)));
            check($sformatf("data c=%0d", c),   int'(dvp_data),    int'(exp_data));
            check($sformatf("fstart c=%0d", c), int'(frame_start), int'(c == 0));
            check($sformatf("busy c=%0d", c),   int'(busy),        1);
            check($sformatf("uf c=%0d", c),     int'(underflow),   int'(exp_uf));
            check($sformatf("rdy c=%0d", c),    int'(pix_ready),   int'(e_rdy(c)));
            if (pix_ready) rdy_cnt++;

            if (c == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_all_zero("async_rst");
                exp_uf = 1'b0;
                return;
            end

            underflow_clr = (c == clr_at);
            if (c == en_off_at) enable = 1'b0;

            nxt_data  = 8'h00;
            v         = 1'b1;
            pix_valid = 1'b1;
            pix_data  = pix_mem[src_idx % 8];
            if (e_rdy(c)) begin
                v         = (pulse != uf_pulse);
                pix_valid = v;
                if (v) begin
                    nxt_data = pix_mem[src_idx % 8][15:8];
                    lo_hold  = pix_mem[src_idx % 8][7:0];
                    src_idx++;
                end else begin
                    lo_hold = 8'h00;
                end
                pulse++;
            end else if (e_href(c + 1)) begin
                nxt_data = lo_hold;
            end

            if (e_rdy(c) && !v) begin
                exp_uf = 1'b1;
            end else if (c == clr_at) begin
                exp_uf = 1'b0;
            end

            tick();
            exp_data = nxt_data;
        end
        underflow_clr = 1'b0;
        pix_valid     = 1'b1;
        check("rdy_count", rdy_cnt, H_ACTIVE * V_ACTIVE);
    endtask

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b0;
        pix_valid = 1'b1;
        pix_data  = pix_mem[0];
        repeat (2) tick();
        check_all_zero("reset");

        // Release with enable high: frame_start right after the first edge.
        rst_n  = 1'b1;
        enable = 1'b1;
        tick();
        run_frame(-1, -1, -1, -1);      // bytes 12,34,56,78,...
        run_frame(-1, -1, -1, -1);      // back-to-back, 55-clock period

        run_frame(2, -1, -1, -1);       // third pixel missing -> 00,00 and sticky flag
        run_frame(-1, 5, -1, -1);       // clear the flag
        run_frame(0, 21, -1, -1);       // clear on the same edge as a new underflow: stays set

        run_frame(-1, 3, 30, -1);       // enable dropped mid-frame: frame still completes
        for (int i = 0; i < 5; i++) begin
            check($sformatf("idle busy %0d", i),   int'(busy),        0);
            check($sformatf("idle fstart %0d", i), int'(frame_start), 0);
            check($sformatf("idle vsync %0d", i),  int'(dvp_vsync),   0);
            check($sformatf("idle href %0d", i),   int'(dvp_href),    0);
            tick();
        end

        enable = 1'b1;
        tick();
        run_frame(-1, -1, -1, 25);      // async reset in the middle of an active line

        repeat (2) tick();
        check_all_zero("in_reset");
        rst_n = 1'b1;
        tick();
        run_frame(-1, -1, -1, -1);      // clean frame after reset

        enable = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dvp_frame_tx.md
Name: dvp_frame_tx

Overview:
- Camera-side DVP transmitter: the other end of the OV5640 capture path.
- Serialises a 16-bit RGB565 pixel stream into 8-bit DVP bytes with OV5640-style timing: vsync pulse, vertical back porch, href-gated active lines, line blanking, vertical front porch.
- Used as an on-board camera emulator, so that the capture/8-to-16 path and the DDR path can be driven with known frames.
- Everything runs on the DVP pixel clock; one output byte per clock.

Parameters:
- H_ACTIVE, 640: pixels per line. Each line carries 2*H_ACTIVE href-high bytes.
- V_ACTIVE, 480: active lines per frame.
- H_BLANK, 144: href-low byte clocks after each active line. Minimum 1.
- VS_LINES, 4: line periods with dvp_vsync high.
- V_BACK, 16: blank line periods between the vsync pulse and the first active line.
- V_FRONT, 8: blank line periods after the last active line.

Ports:
- pclk  in  1  DVP pixel clock, byte rate.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  run request, sampled only at frame boundaries.
- pix_data  in  16  RGB565 pixel: R[15:11], G[10:5], B[4:0].
- pix_valid  in  1  pix_data is valid.
- pix_ready  out  1  transmitter takes a pixel at this clock edge.
- underflow_clr  in  1  clears the underflow flag.
- dvp_vsync  out  1  frame sync, active high.
- dvp_href  out  1  line valid, active high.
- dvp_data  out  8  DVP byte.
- underflow  out  1  sticky flag: a pixel was needed but pix_valid was low.
- frame_start  out  1  one-cycle pulse.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Clock and reset: single clock pclk; rst_n is asynchronous, active-low.
- Output registers: all DVP outputs, frame_start and underflow are registered. pix_ready is combinational from state and counters.
- Reset values: dvp_vsync=0, dvp_href=0, dvp_data=0x00, underflow=0, frame_start=0, busy=0, pix_ready=0. State is IDLE and all counters are 0.
- Line period: LP = 2*H_ACTIVE + H_BLANK clocks, counted by h_cnt (0..LP-1).
- Line counting: v_cnt counts lines within a state. Counter widths are $clog2 of the maximum count plus 1; no wrap occurs inside a valid count.
- States:
  - IDLE: all outputs low.
    - enable=1 at an edge -> VSYNC; dvp_vsync=1 and frame_start=1 after that same edge.
  - VSYNC: VS_LINES*LP clocks, dvp_vsync=1, href=0, data=0x00 -> VBACK.
  - VBACK: V_BACK*LP clocks, all low.
    - V_BACK=0 skips this state.
    - -> ACTIVE.
  - ACTIVE, repeated V_ACTIVE times:
    - h_cnt 0..2*H_ACTIVE-1: href=1.
    - h_cnt 2*H_ACTIVE..LP-1: href=0, data=0x00.
    - After the last line -> VFRONT.
  - VFRONT: V_FRONT*LP clocks, all low.
    - At its end, enable=1 -> VSYNC with frame_start pulse; otherwise -> IDLE.
- Back-to-back frames: no gap cycle between VFRONT and the next VSYNC.
- enable mid-frame: deasserting enable never truncates a frame; the current frame always completes.
- Byte order: high byte pix_data[15:8] is sent first, low byte pix_data[7:0] second. The low byte is held in an internal register.
- pix_ready timing:
  - pix_ready=1 for exactly one clock per pixel: the clock whose edge loads a high byte onto dvp_data.
  - This gives H_ACTIVE pulses per line and H_ACTIVE*V_ACTIVE per frame.
  - The source cannot stall the transmitter. The pixel transfers if pix_valid=1 at that edge.
- Underflow: if pix_valid=0 at a pix_ready edge:
  - both bytes of that pixel are sent as 0x00;
  - underflow is set the following cycle;
  - DVP timing is unchanged.
- underflow_clr: clears underflow. If a new underflow occurs on the same edge, set wins.
- Latency: one clock from a pix_ready edge to the high byte on dvp_data; the low byte follows on the next clock.
- Reset mid-frame: outputs drop to reset values immediately, asynchronously. The transmitter restarts at a frame boundary via IDLE.

Test Plan:
Small parameter set for all scenarios: H_ACTIVE=4, V_ACTIVE=2, H_BLANK=3, VS_LINES=1, V_BACK=1, V_FRONT=1. This gives LP=11 and a 55-clock frame.
1. Reset release, enable held 1, source always valid with pixels 0x1234, 0x5678, ...
   -> frame_start pulses once every 55 clocks.
   -> dvp_vsync is high for 11 clocks, then low.
   -> href goes high at frame clock 22 for 8 clocks, then low 3.
   -> Bytes on dvp_data: 12,34,56,78,...
2. Count pix_ready over one frame -> exactly 8 pulses, each one clock before an href-high byte at even byte index.
3. pix_valid=0 on the 3rd pix_ready edge only -> that pixel is sent as 00,00; underflow=1 from the next clock; timing is identical to scenario 1. Then pulse underflow_clr -> underflow=0.
4. Deassert enable in the middle of frame 1 -> frame 1 completes all 55 clocks, then IDLE with busy=0 and no further frame_start. Reassert enable -> VSYNC begins after the next edge.
5. Assert rst_n=0 during an ACTIVE line -> all outputs are 0 without waiting for a clock edge. After release with enable=1 -> a clean new frame, with frame_start at the first clock.
6. Assert underflow_clr together with a new underflow event -> underflow remains 1.
